queue_dual_clock_gray: RTL and testbench

//  Dual-clock FIFO that moves BIT_WIDTH-wide words from the wclk domain to the rclk domain in FIFO order.

---
 rtl/qdc_pkg.sv | 25 ++
 rtl/qdc_sync_bus.sv | 31 +++
 rtl/queue_dual_clock_gray.sv | 161 ++++++++++++++++
 tb/tb_queue_dual_clock_gray.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qdc_pkg.sv
// Shared helpers for the dual-clock Gray-pointer queue.
//   bin2gray / gray2bin : code conversion for buses up to 32 bits; callers
//                         zero-extend on the way in and cast to their own
//                         width on the way out (upper bits stay zero).
//   qdc_depth_ok        : elaboration check, depth must be a power of two >= 4.
package qdc_pkg;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic bit qdc_depth_ok(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/qdc_sync_bus.sv
// Flop-chain synchroniser for an N-bit bus that changes at most one bit per
// source clock (Gray pointers), or a single reset-release bit at N=1.
//   clk  in  1  destination clock
//   rst  in  1  asynchronous, active-high clear of the whole chain
//   d    in  N  source-domain value
//   q    out N  value after STAGES destination flops
module qdc_sync_bus
    import qdc_pkg::*;
#(
    parameter int N      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [STAGES*N-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[(STAGES-1)*N-1:0], d};
        end
    end

    assign q = chain[STAGES*N-1 -: N];

endmodule

// File: rtl/queue_dual_clock_gray.sv
// Dual-clock FIFO carrying BIT_WIDTH-bit words from wclk to rclk. Pointers
// cross domains as Gray codes; each domain releases reset through its own
// synchroniser. Optional occupancy ports under macro QDC_LEVEL_EN.
//   wclk, rclk          clocks
//   rst                 async active-high reset for both domains
//   din_req/din_ack/din write handshake (din_req = !full)
//   dout_ack/dout_req   read handshake (dout_ack = !empty), dout show-ahead
//   full, almost_full   wclk-domain flags
//   empty, almost_empty rclk-domain flags
//   wlevel, rlevel      per-domain occupancy (QDC_LEVEL_EN only)
module queue_dual_clock_gray
    import qdc_pkg::*;
#(
    parameter int BIT_WIDTH   = 32,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 2,
    parameter int AE_MARGIN   = 2
) (
    input  logic                 wclk,
    input  logic                 rclk,
    input  logic                 rst,
    output logic                 din_req,
    input  logic                 din_ack,
    input  logic [BIT_WIDTH-1:0] din,
    output logic                 dout_ack,
    input  logic                 dout_req,
    output logic [BIT_WIDTH-1:0] dout,
    output logic                 full,
    output logic                 almost_full,
    output logic                 empty,
    output logic                 almost_empty
`ifdef QDC_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] wlevel,
    output logic [$clog2(DEPTH):0] rlevel
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [AW:0] DEPTH_V = PW'(DEPTH);
    localparam logic [AW:0] AF_V    = PW'(AF_MARGIN);
    localparam logic [AW:0] AE_V    = PW'(AE_MARGIN);

    if (!qdc_depth_ok(DEPTH)) begin : g_bad_depth
        $error("queue_dual_clock_gray: DEPTH must be a power of two >= 4");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("queue_dual_clock_gray: SYNC_STAGES must be >= 2");
    end

    // Reset release: each domain leaves reset only after its own chain fills
    // with ones, while assertion propagates asynchronously through the clear.
    logic w_run, r_run, w_rst, r_rst;

    qdc_sync_bus #(.N(1), .STAGES(SYNC_STAGES)) u_wrst_sync (
        .clk(wclk), .rst(rst), .d(1'b1), .q(w_run)
    );
    qdc_sync_bus #(.N(1), .STAGES(SYNC_STAGES)) u_rrst_sync (
        .clk(rclk), .rst(rst), .d(1'b1), .q(r_run)
    );

    assign w_rst = ~w_run;
    assign r_rst = ~r_run;

    logic [BIT_WIDTH-1:0] mem [DEPTH];

    logic [AW:0] wptr, wgray, wptr_next, wgray_next, rgray_s, rptr_w, wocc_next;
    logic [AW:0] rptr, rgray, rptr_next, rgray_next, wgray_s, wptr_r, rocc_next;
    logic        wr_en, rd_en, full_next, af_next, empty_next, ae_next;

    qdc_sync_bus #(.N(PW), .STAGES(SYNC_STAGES)) u_rgray_sync (
        .clk(wclk), .rst(w_rst), .d(rgray), .q(rgray_s)
    );
    qdc_sync_bus #(.N(PW), .STAGES(SYNC_STAGES)) u_wgray_sync (
        .clk(rclk), .rst(r_rst), .d(wgray), .q(wgray_s)
    );

    // ---------------- write domain ----------------
    assign din_req = ~full;
    assign wr_en   = din_ack & ~full;

    always_comb begin
        wptr_next  = wptr + PW'(wr_en);
        wgray_next = PW'(bin2gray(32'(wptr_next)));
        rptr_w     = PW'(gray2bin(32'(rgray_s)));
        wocc_next  = wptr_next - rptr_w;
        // Full when the write pointer is one lap ahead: in Gray code that is
        // the two top bits inverted, the rest equal.
        full_next  = (wgray_next == {~rgray_s[AW:AW-1], rgray_s[AW-2:0]});
        af_next    = ((DEPTH_V - wocc_next) <= AF_V);
    end

    always_ff @(posedge wclk or posedge w_rst) begin
        if (w_rst) begin
            wptr        <= '0;
            wgray       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            wptr        <= wptr_next;
            wgray       <= wgray_next;
            full        <= full_next;
            almost_full <= af_next;
        end
    end

    always_ff @(posedge wclk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    // ---------------- read domain ----------------
    assign dout_ack = ~empty;
    assign rd_en    = dout_req & ~empty;
    assign dout     = empty ? '0 : mem[rptr[AW-1:0]];

    always_comb begin
        rptr_next  = rptr + PW'(rd_en);
        rgray_next = PW'(bin2gray(32'(rptr_next)));
        wptr_r     = PW'(gray2bin(32'(wgray_s)));
        rocc_next  = wptr_r - rptr_next;
        empty_next = (rgray_next == wgray_s);
        ae_next    = (rocc_next <= AE_V);
    end

    always_ff @(posedge rclk or posedge r_rst) begin
        if (r_rst) begin
            rptr         <= '0;
            rgray        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            rptr         <= rptr_next;
            rgray        <= rgray_next;
            empty        <= empty_next;
            almost_empty <= ae_next;
        end
    end

`ifdef QDC_LEVEL_EN
    always_ff @(posedge wclk or posedge w_rst) begin
        if (w_rst) begin
            wlevel <= '0;
        end else begin
            wlevel <= wocc_next;
        end
    end

    always_ff @(posedge rclk or posedge r_rst) begin
        if (r_rst) begin
            rlevel <= '0;
        end else begin
            rlevel <= rocc_next;
        end
    end
`endif

endmodule

// File: tb/tb_queue_dual_clock_gray.sv
// Directed bench for queue_dual_clock_gray (DEPTH=8, SYNC_STAGES=2, margins 2).
module tb_queue_dual_clock_gray;

    localparam int BW    = 32;
    localparam int DEPTH = 8;
    localparam int N_T5  = 300;

    logic          wclk = 1'b0;
    logic          rclk = 1'b0;
    logic          rst = 1'b0;
    logic          din_ack = 1'b0;
    logic          dout_req = 1'b0;
    logic [BW-1:0] din = '0;
    logic          din_req, dout_ack, full, almost_full, empty, almost_empty;
    logic [BW-1:0] dout;
`ifdef QDC_LEVEL_EN
    logic [3:0]    wlevel, rlevel;
`endif

    int whalf = 5;
    int rhalf = 14;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb [$];

    always #(whalf) wclk = ~wclk;
    always #(rhalf) rclk = ~rclk;

    queue_dual_clock_gray #(
        .BIT_WIDTH(BW), .DEPTH(DEPTH), .SYNC_STAGES(2), .AF_MARGIN(2), .AE_MARGIN(2)
    ) dut (
        .wclk(wclk), .rclk(rclk), .rst(rst),
        .din_req(din_req), .din_ack(din_ack), .din(din),
        .dout_ack(dout_ack), .dout_req(dout_req), .dout(dout),
        .full(full), .almost_full(almost_full),
        .empty(empty), .almost_empty(almost_empty)
`ifdef QDC_LEVEL_EN
        , .wlevel(wlevel), .rlevel(rlevel)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        @(negedge wclk);
        din     = d;
        din_ack = 1'b1;
        @(negedge wclk);
        din_ack = 1'b0;
    endtask

    task automatic push_sb(input logic [31:0] d, input string tag);
        int k;
        k = 0;
        @(negedge wclk);
        while (!din_req && k < 100) begin
            @(negedge wclk);
            k++;
        end
        if (!din_req) begin
            check({tag, "_din_req_timeout"}, 32'(din_req), 1);
            return;
        end
        din     = d;
        din_ack = 1'b1;
        sb.push_back(d);
        @(negedge wclk);
        din_ack = 1'b0;
    endtask

    task automatic pop_exp(input logic [31:0] exp, input string tag);
        int k;
        k = 0;
        @(negedge rclk);
        while (!dout_ack && k < 100) begin
            @(negedge rclk);
            k++;
        end
        if (!dout_ack) begin
            check({tag, "_dout_ack_timeout"}, 32'(dout_ack), 1);
            return;
        end
        check(tag, dout, exp);
        dout_req = 1'b1;
        @(negedge rclk);
        dout_req = 1'b0;
    endtask

    task automatic pop_sb(input string tag);
        logic [31:0] e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        pop_exp(e, tag);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_empty"},        32'(empty), 1);
        check({tag, "_almost_empty"}, 32'(almost_empty), 1);
        check({tag, "_full"},         32'(full), 0);
        check({tag, "_almost_full"},  32'(almost_full), 0);
        check({tag, "_din_req"},      32'(din_req), 1);
        check({tag, "_dout_ack"},     32'(dout_ack), 0);
        check({tag, "_dout"},         dout, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: asynchronous reset pulse, checked while held and after release
        #3 rst = 1'b1;
        #7;
        check_idle("t1_in_reset");
        #17 rst = 1'b0;
        repeat (6) @(negedge rclk);
        check_idle("t1_released");

        // T2: fill to full, ignored extra write, drain in order
        for (int i = 0; i < 8; i++) push(32'(i));
        check("t2_full", 32'(full), 1);
        check("t2_din_req", 32'(din_req), 0);
        check("t2_almost_full", 32'(almost_full), 1);
        push(32'hDEAD_BEEF);
        check("t2_full_after_9th", 32'(full), 1);
        for (int i = 0; i < 8; i++) pop_exp(32'(i), "t2_data");
        check("t2_empty", 32'(empty), 1);
        check("t2_dout_ack", 32'(dout_ack), 0);
        check("t2_dout_zero", dout, 0);
        repeat (8) @(negedge rclk);
        check("t2_no_9th_word", 32'(dout_ack), 0);

        // T3: watermark thresholds on both sides
        repeat (8) @(negedge wclk);
        for (int i = 0; i < 5; i++) push(32'h10 + 32'(i));
        check("t3_af_occ5", 32'(almost_full), 0);
        push(32'h15);
        check("t3_af_occ6", 32'(almost_full), 1);
        check("t3_full_occ6", 32'(full), 0);
        repeat (6) @(negedge rclk);
        check("t3_ae_occ6", 32'(almost_empty), 0);
        pop_exp(32'h10, "t3_data");
        repeat (8) @(negedge wclk);
        check("t3_af_back_occ5", 32'(almost_full), 0);
        pop_exp(32'h11, "t3_data");
        pop_exp(32'h12, "t3_data");
        check("t3_ae_rocc3", 32'(almost_empty), 0);
        pop_exp(32'h13, "t3_data");
        check("t3_ae_rocc2", 32'(almost_empty), 1);
        pop_exp(32'h14, "t3_data");
        pop_exp(32'h15, "t3_data");
        check("t3_empty", 32'(empty), 1);

        // T4: 3*DEPTH+3 interleaved words with random stalls, across pointer wrap
        for (int i = 0; i < 3 * DEPTH + 3; i++) begin
            if (sb.size() >= 6) pop_sb("t4_data");
            push_sb(32'h100 + 32'(i), "t4");
            repeat ($urandom_range(0, 2)) @(negedge wclk);
            if ($urandom_range(0, 1) == 1) pop_sb("t4_data");
        end
        while (sb.size() > 0) pop_sb("t4_data");
        check("t4_empty", 32'(empty), 1);

        // T5: clock-ratio sweep, concurrent producer/consumer with scoreboard
        for (int r = 0; r < 2; r++) begin
            whalf = (r == 0) ? 15 : 5;
            rhalf = (r == 0) ? 5 : 15;
            repeat (4) @(negedge wclk);
            fork
                begin
                    int sent, cyc;
                    sent = 0;
                    cyc  = 0;
                    while (sent < N_T5 && cyc < 6000) begin
                        @(negedge wclk);
                        cyc++;
                        if (din_req && $urandom_range(0, 3) != 0) begin
                            din     = $urandom;
                            din_ack = 1'b1;
                            sb.push_back(din);
                            sent++;
                        end else begin
                            din_ack = 1'b0;
                        end
                    end
                    @(negedge wclk);
                    din_ack = 1'b0;
                    check("t5_sent", 32'(sent), N_T5);
                end
                begin
                    int got, cyc;
                    logic [31:0] e;
                    got = 0;
                    cyc = 0;
                    while (got < N_T5 && cyc < 6000) begin
                        @(negedge rclk);
                        cyc++;
                        if (dout_ack && $urandom_range(0, 3) != 0) begin
                            check("t5_no_underflow", 32'(sb.size() != 0), 1);
                            if (sb.size() != 0) begin
                                e = sb.pop_front();
                                check("t5_data", dout, e);
                            end
                            dout_req = 1'b1;
                            got++;
                        end else begin
                            dout_req = 1'b0;
                        end
                    end
                    @(negedge rclk);
                    dout_req = 1'b0;
                    check("t5_got", 32'(got), N_T5);
                end
            join
            check("t5_sb_drained", 32'(sb.size()), 0);
            repeat (4) @(negedge rclk);
            check("t5_empty", 32'(empty), 1);
        end
        whalf = 5;
        rhalf = 14;

        // T6: reset with five words queued; contents discarded
        repeat (4) @(negedge wclk);
        for (int i = 0; i < 5; i++) push(32'h60 + 32'(i));
        repeat (8) @(negedge rclk);
        check("t6_pre_dout_ack", 32'(dout_ack), 1);
        check("t6_pre_dout", dout, 32'h60);
        #3 rst = 1'b1;
        #41 rst = 1'b0;
        sb.delete();
        repeat (8) @(negedge rclk);
        check_idle("t6_after_reset");
        push(32'h77);
        pop_exp(32'h77, "t6_first_read");
        repeat (6) @(negedge rclk);
        check("t6_empty_end", 32'(empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
